// File: rtl/vga_overlay_pkg.sv
`default_nettype none
// ============================================================================
// vga_overlay_pkg : overlay mode encodings and score-banner window defaults
// Rev 1.0
// ============================================================================
package vga_overlay_pkg;

    typedef enum logic [1:0] {
        OVL_OFF    = 2'd0,
        OVL_STATIC = 2'd1,
        OVL_BLINK  = 2'd2,
        OVL_FLASH  = 2'd3
    } ovl_mode_e;

    localparam int          OVL_X0          = 40;
    localparam int          OVL_Y0          = 210;
    localparam int          OVL_WIN_W       = 240;
    localparam int          OVL_WIN_H       = 120;
    localparam int          OVL_NUM_IMG     = 2;
    localparam int          OVL_ADDR_W      = 16;
    localparam logic [25:0] OVL_BLINK_TICKS = 26'd12_500_000;

    // A single image still needs a one-bit selector port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ovl_delay_line.sv
`default_nettype none
// ============================================================================
// ovl_delay_line : DEPTH-stage, WIDTH-bit shift register with async reset
// Rev 1.0
// ============================================================================
module ovl_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/score_banner_overlay.sv
`default_nettype none
// ============================================================================
// score_banner_overlay : windowed 1-bit image ROM overlay with blink/flash
// Rev 1.0
// ============================================================================
module score_banner_overlay
    import vga_overlay_pkg::*;
#(
    parameter int          X0          = OVL_X0,
    parameter int          Y0          = OVL_Y0,
    parameter int          WIN_W       = OVL_WIN_W,
    parameter int          WIN_H       = OVL_WIN_H,
    parameter int          NUM_IMG     = OVL_NUM_IMG,
    parameter int          ADDR_W      = OVL_ADDR_W,
    parameter logic [25:0] BLINK_TICKS = OVL_BLINK_TICKS,
    parameter int          ROM_LAT     = 1,
    parameter int          INVERT      = 1,
    parameter int          SEL_W       = sel_width(NUM_IMG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       col_addr_sig,
    input  logic [10:0]       row_addr_sig,
    input  logic [1:0]        mode,
    input  logic [SEL_W-1:0]  img_sel,
    input  logic [SEL_W-1:0]  alt_sel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data,
    output logic              pixel_out,
    output logic              pixel_valid
);

    localparam int DL_DEPTH = 1 + ROM_LAT;

    logic              w_in_win;
    logic              w_fs;
    logic [SEL_W-1:0]  w_act;
    logic [ADDR_W-1:0] w_base;
    logic [3:0]        w_dl_in;
    logic [3:0]        w_dl_out;
    logic              w_bit;

    logic [25:0]       r_blink_cnt;
    logic              r_phase;
    ovl_mode_e         r_mode;
    logic              r_frame_phase;
    logic              r_frame_ok;
    logic [ADDR_W-1:0] r_addr_cnt;

    assign w_in_win = (col_addr_sig >= 11'(X0)) && (col_addr_sig < 11'(X0 + WIN_W)) &&
                      (row_addr_sig >= 11'(Y0)) && (row_addr_sig < 11'(Y0 + WIN_H));
    assign w_fs     = (col_addr_sig == 11'(X0)) && (row_addr_sig == 11'(Y0));

    // Base lookup over elaboration-time constants; unmatched index falls to image 0.
    always_comb begin
        w_act  = ((mode == OVL_BLINK) && r_phase) ? alt_sel : img_sel;
        w_base = '0;
        for (int k = 0; k < NUM_IMG; k++) begin
            if (w_act == SEL_W'(k)) w_base = ADDR_W'(k * WIN_W * WIN_H);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BLINK_TICKS) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 26'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode        <= OVL_OFF;
            r_frame_phase <= 1'b0;
            r_frame_ok    <= 1'b0;
            r_addr_cnt    <= '0;
            rom_addr      <= '0;
        end else begin
            if (w_fs) begin
                r_mode        <= ovl_mode_e'(mode);
                r_frame_phase <= r_phase;
                r_frame_ok    <= 1'b1;
                rom_addr      <= w_base;
                r_addr_cnt    <= w_base + ADDR_W'(1);
            end else if (w_in_win) begin
                rom_addr      <= r_addr_cnt;
                r_addr_cnt    <= r_addr_cnt + ADDR_W'(1);
            end else begin
                rom_addr      <= '0;
            end
        end
    end

    // The frame-start pixel must already see the values being latched for its frame.
    assign w_dl_in = {w_in_win & (w_fs | r_frame_ok),
                      w_fs ? mode    : 2'(r_mode),
                      w_fs ? r_phase : r_frame_phase};

    ovl_delay_line #(
        .DEPTH (DL_DEPTH),
        .WIDTH (4)
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_dl_in),
        .o_q   (w_dl_out)
    );

    assign w_bit = rom_data ^ (INVERT != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out   <= 1'b0;
            pixel_valid <= 1'b0;
        end else if (!w_dl_out[3]) begin
            pixel_out   <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= 1'b1;
            case (ovl_mode_e'(w_dl_out[2:1]))
                OVL_STATIC, OVL_BLINK: pixel_out <= w_bit;
                OVL_FLASH:             pixel_out <= w_dl_out[0] ? 1'b0 : w_bit;
                default:               pixel_out <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_score_banner_overlay.sv
`default_nettype none
// ============================================================================
// tb_score_banner_overlay : two overlay instances (ROM latency 1 and 3) driven
// with a shared raster; scoreboard queues plus a spot-check vector table.
// Rev 1.0
// ============================================================================
module tb_score_banner_overlay;

    localparam int BT = 100;
    localparam int HN = 50000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] col = '0;
    logic [10:0] row = '0;
    logic [1:0]  mode = 2'd0;
    logic        img_sel = 1'b0;
    logic        alt_sel = 1'b1;
    logic [15:0] addr_a, addr_b;
    logic        rd_a, rd_b, pix_a, val_a, pix_b, val_b;

    int checks = 0;
    int failures = 0;

    score_banner_overlay #(.BLINK_TICKS(26'd100), .ROM_LAT(1), .INVERT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .col_addr_sig(col), .row_addr_sig(row),
        .mode(mode), .img_sel(img_sel), .alt_sel(alt_sel),
        .rom_addr(addr_a), .rom_data(rd_a), .pixel_out(pix_a), .pixel_valid(val_a));

    score_banner_overlay #(.BLINK_TICKS(26'd100), .ROM_LAT(3), .INVERT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .col_addr_sig(col), .row_addr_sig(row),
        .mode(mode), .img_sel(img_sel), .alt_sel(alt_sel),
        .rom_addr(addr_b), .rom_data(rd_b), .pixel_out(pix_b), .pixel_valid(val_b));

    always #5 clk = ~clk;

    // ROM models: contents are addr[0], or all ones when rom_ones is set
    logic       rom_ones = 1'b0;
    logic       rp_a = 1'b0;
    logic [2:0] rp_b = '0;

    function automatic logic romf(input logic [15:0] a);
        return rom_ones ? 1'b1 : a[0];
    endfunction

    always @(posedge clk) begin
        rp_a <= romf(addr_a);
        rp_b <= {rp_b[1:0], romf(addr_b)};
    end
    assign rd_a = rp_a;
    assign rd_b = rp_b[2];

    // Behavioural reference model
    typedef struct packed { logic v; logic p; } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    int   m_cnt, m_acnt;
    logic m_phase, m_phl, m_ok;
    logic [1:0] m_mode;

    logic [15:0] h_addr [HN];
    logic        h_pa [HN];
    logic        h_va [HN];
    logic        h_pb [HN];
    logic        h_vb [HN];
    int gt = 0;
    int fs_addr_a = -1;
    int n_va = 0, n_vb = 0, n_b1 = 0, n_b0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic pixf(input logic [1:0] m, input logic ph, input logic bx);
        case (m)
            2'd0:       return 1'b0;
            2'd1, 2'd2: return bx;
            default:    return ph ? 1'b0 : bx;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_acnt = 0; m_phase = 1'b0; m_phl = 1'b0; m_ok = 1'b0; m_mode = 2'd0;
        qa.delete();
        qb.delete();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        check("reset_rom_addr_a", 32'(addr_a), 0);
        check("reset_rom_addr_b", 32'(addr_b), 0);
        check("reset_pix_a", {30'd0, val_a, pix_a}, 0);
        check("reset_pix_b", {30'd0, val_b, pix_b}, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic tick(input int c, input int r);
        int   exp_addr;
        logic inw, fs, chk_addr, b, act;
        exp_t ea, eb;
        col = 11'(c);
        row = 11'(r);
        inw = (c >= 40) && (c < 280) && (r >= 210) && (r < 330);
        fs  = (c == 40) && (r == 210);
        if (fs) begin
            act      = (mode == 2'd2 && m_phase) ? alt_sel : img_sel;
            exp_addr = act ? 28800 : 0;
            m_acnt   = exp_addr + 1;
            m_mode   = mode;
            m_phl    = m_phase;
            m_ok     = 1'b1;
        end else if (inw) begin
            exp_addr = m_acnt;
            m_acnt++;
        end else begin
            exp_addr = 0;
        end
        chk_addr = m_ok || !inw;
        ea = '0;
        eb = '0;
        if (inw && m_ok) begin
            b    = romf(16'(exp_addr));
            ea.v = 1'b1;
            eb.v = 1'b1;
            ea.p = pixf(m_mode, m_phl, ~b);
            eb.p = pixf(m_mode, m_phl, b);
        end
        qa.push_back(ea);
        qb.push_back(eb);
        if (m_cnt == BT) begin
            m_cnt = 0;
            m_phase = ~m_phase;
        end else begin
            m_cnt++;
        end

        @(posedge clk);
        #1;
        if (gt < HN) begin
            h_addr[gt] = addr_a; h_pa[gt] = pix_a; h_va[gt] = val_a;
            h_pb[gt] = pix_b; h_vb[gt] = val_b;
        end
        gt++;
        if (fs) fs_addr_a = int'(addr_a);
        if (val_a) n_va++;
        if (val_b) begin
            n_vb++;
            if (pix_b) n_b1++; else n_b0++;
        end
        if (chk_addr) begin
            check("rom_addr_a", 32'(addr_a), 32'(exp_addr));
            check("rom_addr_b", 32'(addr_b), 32'(exp_addr));
        end
        if (qa.size() == 3) begin
            ea = qa.pop_front();
            check("pix_a", {30'd0, val_a, pix_a}, {30'd0, ea.v, ea.p});
        end
        if (qb.size() == 5) begin
            eb = qb.pop_front();
            check("pix_b", {30'd0, val_b, pix_b}, {30'd0, eb.v, eb.p});
        end
    endtask

    task automatic short_frame();
        for (int r = 209; r <= 212; r++)
            for (int c = 38; c <= 47; c++) tick(c, r);
    endtask

    typedef struct {
        int c; int r; int addr;
        logic va; logic pa; logic vb; logic pb;
    } vec_t;
    vec_t tbl[9];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    initial begin
        int gt0, saw0, saw1, chg, prev;
        tbl[0] = '{40, 210, 0,     1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{41, 210, 1,     1'b1, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{279, 210, 239,  1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{280, 210, 0,    1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{39, 210, 0,     1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{40, 251, 9840,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{279, 329, 28799, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{40, 330, 0,     1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{40, 209, 0,     1'b0, 1'b0, 1'b0, 1'b0};

        #1;
        reset_dut();

        // Frame 1: full window, static image 0; img_sel flips to 1 mid-frame
        mode = 2'd1;
        img_sel = 1'b0;
        gt0 = gt;
        for (int r = 209; r <= 331; r++)
            for (int c = 38; c <= 281; c++) begin
                if (r == 250 && c == 38) img_sel = 1'b1;
                tick(c, r);
            end
        for (int i = 0; i < 9; i++) begin
            int k;
            k = gt0 + (tbl[i].r - 209) * 244 + (tbl[i].c - 38);
            check($sformatf("vec%0d_addr", i), 32'(h_addr[k]), 32'(tbl[i].addr));
            check($sformatf("vec%0d_pix_a", i), {30'd0, h_va[k+2], h_pa[k+2]}, {30'd0, tbl[i].va, tbl[i].pa});
            check($sformatf("vec%0d_pix_b", i), {30'd0, h_vb[k+4], h_pb[k+4]}, {30'd0, tbl[i].vb, tbl[i].pb});
        end

        // Frame 2: image 1 from fs, then reset at row 260
        for (int r = 209; r <= 265; r++)
            for (int c = 38; c <= 281; c++) begin
                if (r == 260 && c == 100) begin
                    reset_dut();
                    n_va = 0;
                    n_vb = 0;
                end
                tick(c, r);
                if (r == 210 && c == 40) check("frame2_fs_addr", 32'(addr_a), 28800);
            end
        check("post_reset_valid_a", 32'(n_va), 0);
        check("post_reset_valid_b", 32'(n_vb), 0);

        // Frame 3: output resumes at the next frame start
        n_va = 0;
        short_frame();
        check("resume_fs_addr", 32'(fs_addr_a), 28800);
        check("resume_valid_seen", 32'(n_va != 0), 1);

        // Blink: primary/alternate images on successive short frames
        mode = 2'd2;
        img_sel = 1'b0;
        alt_sel = 1'b1;
        saw0 = 0; saw1 = 0; chg = 0; prev = -1;
        for (int f = 0; f < 16; f++) begin
            short_frame();
            if (fs_addr_a == 0) saw0++;
            else if (fs_addr_a == 28800) saw1++;
            if (prev >= 0 && fs_addr_a != prev) chg++;
            prev = fs_addr_a;
        end
        check("blink_fs_addr_legal", 32'(saw0 + saw1), 16);
        check("blink_saw_img0", 32'(saw0 != 0), 1);
        check("blink_saw_img1", 32'(saw1 != 0), 1);
        check("blink_alternates", 32'(chg >= 2), 1);

        // Flash: all-ones ROM, blank frames in phase 1
        rom_ones = 1'b1;
        mode = 2'd3;
        n_b1 = 0;
        n_b0 = 0;
        for (int f = 0; f < 12; f++) short_frame();
        check("flash_saw_on", 32'(n_b1 != 0), 1);
        check("flash_saw_off", 32'(n_b0 != 0), 1);

        // Off: in-window pixels are 0
        mode = 2'd0;
        for (int f = 0; f < 2; f++) short_frame();
        for (int i = 0; i < 6; i++) tick(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_banner_overlay.md
# score_banner_overlay

Parametrised window-overlay renderer for the VGA pipeline. It maps the scan position onto a rectangular window and generates addresses for a 1-bit image ROM that holds NUM_IMG stacked images. It returns the delay-aligned overlay pixel, with static, alternating-blink and flash modes. It sits between the VGA sync/coordinate generator and the colour mux, alongside the playfield and next-piece renderers.

## Interface
- X0, 40, window left column (inclusive)
- Y0, 210, window top row (inclusive)
- WIN_W, 240, window width in pixels
- WIN_H, 120, window height in rows
- NUM_IMG, 2, images stacked in ROM; image k occupies k*WIN_W*WIN_H .. (k+1)*WIN_W*WIN_H-1
- ADDR_W, 16, ROM address width; must hold NUM_IMG*WIN_W*WIN_H-1
- BLINK_TICKS, 26'd12_500_000, clk cycles per blink half-period
- ROM_LAT, 1, ROM read latency in cycles (1..3)
- INVERT, 1, 1 = pixel_out is the inverted ROM bit inside the window
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- col_addr_sig  in  11  current scan column
- row_addr_sig  in  11  current scan row
- mode  in  2  0 off, 1 static, 2 blink (primary/alt alternate), 3 flash (primary/blank alternate)
- img_sel  in  clog2(NUM_IMG)  primary image index
- alt_sel  in  clog2(NUM_IMG)  alternate image index for mode 2
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  1  ROM output, valid ROM_LAT cycles after rom_addr
- pixel_out  out  1  overlay pixel, 1 = draw
- pixel_valid  out  1  1 when pixel_out corresponds to an in-window pixel

## Operation
- in_win = col in [X0, X0+WIN_W) and row in [Y0, Y0+WIN_H), evaluated combinationally on the inputs.
- Frame start (fs) = col==X0 and row==Y0. At fs the block latches mode, the blink phase, and the active image index. Active image = img_sel, except alt_sel when mode==2 and phase==1. These values hold for the whole frame, so there is no tearing.
- Blink counter: a free-running counter counts 0..BLINK_TICKS, then wraps to 0 and toggles phase. It runs in every mode.
- Address generator: incremental, no multiplier. At fs, addr_cnt loads base(active) + 1 and rom_addr gets base(active). At any other in_win cycle, rom_addr gets addr_cnt and addr_cnt increments. Outside the window, rom_addr is 0 and addr_cnt holds. Row-major continuity follows from the raster order.
- base(k) = k*WIN_W*WIN_H, computed from a constant lookup (elaboration-time); an out-of-range index clamps to image 0.
- frame_ok is cleared by reset and set at fs. While frame_ok==0, in-window pixels output 0 and pixel_valid is 0. A reset mid-frame therefore never shows a partial image.
- Pixel decision, on the aligned bit b:
  - mode 0: 0
  - mode 1 or 2: b xor INVERT
  - mode 3: b xor INVERT when phase 0, 0 when phase 1
  - outside the window: pixel_out=0 and pixel_valid=0

## Timing
- Latency from coordinates to pixel_out is 2+ROM_LAT cycles: rom_addr at t+1, rom_data at t+1+ROM_LAT, pixel_out registered at t+2+ROM_LAT.
- in_win and the latched mode/phase ride a delay line (1+ROM_LAT stages) to align with rom_data.
- Reset values: rom_addr=0, pixel_out=0, pixel_valid=0, phase=0, blink counter=0, frame_ok=0, latched mode=0. All delay-line stages are 0.
- Changes to mode, img_sel or alt_sel between frame starts take effect at the next fs only.
- A blink toggle mid-frame takes effect at the next fs.
- Coordinates jumping backwards are tolerated; the address resynchronises at the next fs.

## Structure
- Shared package (vga_overlay_pkg): mode encodings (OVL_OFF, OVL_STATIC, OVL_BLINK, OVL_FLASH) and the default window constants for the score banner.
- One sub-module, ovl_delay_line: a parametrised depth/width shift register with async reset. It is used for the in_win/mode/phase alignment and is reusable by the next-piece renderer.

## Test plan
- Reset, then mode=1, img_sel=0, ROM model where data = addr[0] with ROM_LAT=1, full 640x480 scan: pixel (40,210) gives rom_addr=0 and pixel_out=1 three cycles later. Pixel (279,329) gives rom_addr=28799. Pixel (280,210) gives pixel_valid=0.
- mode=2, img_sel=0, alt_sel=1, BLINK_TICKS=100, short frames: rom_addr at fs alternates between 0 and 28800 on successive frames after each toggle.
- mode=3, INVERT=0, ROM all ones: in-window pixel_out alternates between 1 and 0 across blink phases; pixel_valid stays 1.
- Change img_sel from 0 to 1 at row 250: rom_addr continues in image 0 until the next fs, then starts at 28800.
- Assert rst_n low at row 260 and release it: pixel_out=0 and pixel_valid=0 for the rest of that frame; normal output resumes at the next fs.
- Rerun with ROM_LAT=3: pixel_out lags the coordinates by exactly 5 cycles; window edges are cycle-exact.
